fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 25 ++
 rtl/fetch_unit.sv | 119 +++++++++++
 tb/tb_fetch_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-side bundle: memory request/response, execute redirect, and decode hand-off.
// The fetch unit uses the master modport. The memory/execute/decode environment uses the slave modport.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    modport master (
        output imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, stall
    );

    modport slave (
        input  imem_req_valid, imem_addr, if_valid, if_instr, if_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, stall
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch with 2 credits shared by in-flight requests and the 2-entry decode buffer.
// The first request issues one cycle after reset release. Stall only holds the buffer head. Redirect flushes the buffer and drains stale responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [1:0]  outstanding, outstanding_nxt;
    entry_t      ibuf [2];
    logic        head;
    logic [1:0]  count;
    logic [31:0] last_pc;

    logic        redirect;
    logic [2:0]  credits_used;
    logic        req_valid;
    logic        req_fire;
    logic        rsp_take;
    logic        push;
    logic        pop;
    logic        wr_idx;
    logic [31:0] rsp_pc;
    logic        buf_valid;

    assign redirect     = bus.redirect_valid;
    assign credits_used = {1'b0, outstanding} + {1'b0, count};
    assign req_valid    = (state == FETCH) && !redirect && (credits_used < 3'd2);
    assign req_fire     = req_valid && bus.imem_req_ready;
    assign rsp_take     = bus.imem_rsp_valid && (outstanding != 2'd0);
    assign buf_valid    = (count != 2'd0);
    assign push         = (state == FETCH) && !redirect && rsp_take && (count != 2'd2);
    assign pop          = buf_valid && !bus.stall;
    assign wr_idx       = head ^ count[0];

    // In FETCH the in-flight requests are the words immediately below fetch_pc, so the oldest one is recoverable.
    assign rsp_pc = fetch_pc - {28'b0, outstanding, 2'b00};

    always_comb begin
        state_nxt       = state;
        fetch_pc_nxt    = fetch_pc;
        outstanding_nxt = outstanding;

        case ({req_fire, rsp_take})
            2'b10:   outstanding_nxt = outstanding + 2'd1;
            2'b01:   outstanding_nxt = outstanding - 2'd1;
            default: outstanding_nxt = outstanding;
        endcase

        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   state_nxt = FETCH;
            DRAIN:   state_nxt = (outstanding == 2'd0) ? FETCH : DRAIN;
            default: state_nxt = IDLE;
        endcase

        if (req_fire) begin
            fetch_pc_nxt = fetch_pc + 32'd4;
        end

        if (redirect) begin
            fetch_pc_nxt = {bus.redirect_pc[31:2], 2'b00};
            state_nxt    = ((state == DRAIN) || (outstanding_nxt != 2'd0)) ? DRAIN : FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            outstanding <= 2'd0;
        end else begin
            state       <= state_nxt;
            fetch_pc    <= fetch_pc_nxt;
            outstanding <= outstanding_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ibuf[0] <= '0;
            ibuf[1] <= '0;
            head    <= 1'b0;
            count   <= 2'd0;
            last_pc <= RESET_PC;
        end else begin
            if (pop) begin
                last_pc <= ibuf[head].pc;
            end
            if (redirect) begin
                head  <= 1'b0;
                count <= 2'd0;
            end else begin
                if (push) begin
                    ibuf[wr_idx] <= '{pc: rsp_pc, instr: bus.imem_rsp_data};
                end
                head  <= head ^ pop;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_addr      = fetch_pc;
    assign bus.if_valid       = buf_valid;
    assign bus.if_instr       = buf_valid ? ibuf[head].instr : NOP_INSTR;
    assign bus.if_pc          = buf_valid ? ibuf[head].pc : last_pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit with an in-order memory model and an expected instruction-stream model.
`timescale 1ns/1ps
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem_q [$];
    logic [31:0] exp_q [$];
    logic [31:0] req_exp = RESET_PC;
    int          tokens = 0;
    int          stale = 0;
    int          acc_count = 0;
    int          pop_count = 0;
    logic        prev_hold = 1'b0;
    logic        prev_redir = 1'b0;
    logic [31:0] prev_pc = '0;
    logic [31:0] prev_instr = '0;

    int   stall_pct = 0;
    int   ready_pct = 100;
    int   rsp_pct = 100;
    int   redir_pct = 0;
    logic rsp_en = 1'b1;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A3C_96E1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, req, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check1({tag, "_req_valid"}, bus.imem_req_valid, 1'b0);
        check({tag, "_addr"}, bus.imem_addr, RESET_PC);
        check1({tag, "_if_valid"}, bus.if_valid, 1'b0);
        check({tag, "_if_instr"}, bus.if_instr, NOP);
        check({tag, "_if_pc"}, bus.if_pc, RESET_PC);
    endtask

    // Monitor and scoreboard.
    initial begin
        logic [31:0] e;
        logic [31:0] t;
        exp_q.push_back(RESET_PC);
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check_reset_outputs("rst");
                mem_q.delete();
                exp_q.delete();
                exp_q.push_back(RESET_PC);
                req_exp    = RESET_PC;
                tokens     = 0;
                stale      = 0;
                prev_hold  = 1'b0;
                prev_redir = 1'b0;
            end else begin
                if (bus.redirect_valid) check1("no_req_on_redirect", bus.imem_req_valid, 1'b0);
                if (!bus.if_valid) check("empty_nop", bus.if_instr, NOP);
                if (prev_redir) begin
                    check1("flush_after_redirect", bus.if_valid, 1'b0);
                end else if (prev_hold) begin
                    check1("hold_valid", bus.if_valid, 1'b1);
                    check("hold_pc", bus.if_pc, prev_pc);
                    check("hold_instr", bus.if_instr, prev_instr);
                end
                if (bus.imem_rsp_valid) begin
                    if (mem_q.size() > 0) void'(mem_q.pop_front());
                    if (stale > 0) stale--;
                end
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    check("req_addr", bus.imem_addr, req_exp);
                    check("no_req_while_draining", 32'(stale), 32'd0);
                    mem_q.push_back(bus.imem_addr);
                    req_exp = req_exp + 32'd4;
                    tokens++;
                    check1("credit_limit", tokens <= 2, 1'b1);
                    acc_count++;
                end
                if (bus.if_valid && !bus.stall) begin
                    e = exp_q.pop_front();
                    check("pop_pc", bus.if_pc, e);
                    check("pop_instr", bus.if_instr, mem_fn(e));
                    exp_q.push_back(e + 32'd4);
                    tokens--;
                    pop_count++;
                end
                if (bus.redirect_valid) begin
                    t = {bus.redirect_pc[31:2], 2'b00};
                    exp_q.delete();
                    exp_q.push_back(t);
                    req_exp = t;
                    tokens  = 0;
                    stale   = mem_q.size();
                end
                prev_redir = bus.redirect_valid;
                prev_hold  = bus.if_valid && bus.stall && !bus.redirect_valid;
                prev_pc    = bus.if_pc;
                prev_instr = bus.if_instr;
            end
        end
    end

    task automatic drive();
        if (rsp_en && (mem_q.size() > 0) && ($urandom_range(99) < rsp_pct)) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = mem_fn(mem_q[0]);
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = $urandom();
        end
        bus.stall          = ($urandom_range(99) < stall_pct);
        bus.imem_req_ready = ($urandom_range(99) < ready_pct);
        bus.redirect_valid = ($urandom_range(99) < redir_pct);
        bus.redirect_pc    = $urandom_range(1) ? $urandom() : ($urandom() & 32'h0000_0FFF);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
    endtask

    initial begin
        int a;
        int p0;
        bit found;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.stall          = 1'b0;

        // Reset held, then released mid-cycle. There is one IDLE cycle before the first request.
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1 check1("idle_no_req", bus.imem_req_valid, 1'b0);
        step();
        check1("first_req_valid", bus.imem_req_valid, 1'b1);
        check("first_req_addr", bus.imem_addr, RESET_PC);

        // Streaming with an always-ready memory and 1-cycle responses.
        repeat (20) step();
        check1("stream_progress", pop_count >= 5, 1'b1);

        // Hold stall for 5 cycles. Credits bound the number of new requests.
        a = acc_count;
        stall_pct = 100;
        repeat (5) step();
        check1("stall_accepts_le2", (acc_count - a) <= 2, 1'b1);
        stall_pct = 0;
        repeat (10) step();

        // Redirect with two requests in flight. Stale responses must be dropped.
        rsp_en = 1'b0;
        repeat (6) step();
        check("two_outstanding", 32'(mem_q.size()), 32'd2);
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0102;
        rsp_en = 1'b1;
        p0 = pop_count;
        repeat (12) step();
        check1("resume_after_redirect", pop_count > p0, 1'b1);

        // Redirect in the same cycle as a response and a pop.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (bus.if_valid && bus.imem_rsp_valid) begin
                bus.redirect_valid = 1'b1;
                bus.redirect_pc    = 32'h0000_0200;
                found = 1'b1;
            end
        end
        check1("coincident_setup", found, 1'b1);
        repeat (10) step();

        // Address wrap past 0xFFFF_FFFC.
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFF9;
        p0 = pop_count;
        repeat (12) step();
        check1("wrap_progress", pop_count >= p0 + 3, 1'b1);

        // Randomized traffic.
        stall_pct = 30; ready_pct = 70; rsp_pct = 70; redir_pct = 5;
        p0 = pop_count;
        repeat (2000) step();
        check1("random_progress", pop_count > p0 + 100, 1'b1);
        stall_pct = 0; ready_pct = 100; rsp_pct = 100; redir_pct = 0;
        repeat (10) step();

        // Asynchronous reset between clock edges mid-fetch.
        @(posedge clk);
        #3 rst_n = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.redirect_valid = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();
        check1("post_rst_req_valid", bus.imem_req_valid, 1'b1);
        check("post_rst_req_addr", bus.imem_addr, RESET_PC);
        p0 = pop_count;
        repeat (20) step();
        check1("post_rst_progress", pop_count > p0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
